rv32_instr_realigner: RTL



---
 rtl/rv32_instr_realigner.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rv32_instr_realigner.sv
// Halfword-granular instruction buffer between fetch and decode: realigns 32-bit
// fetch words into one RVC parcel or one (possibly straddling) 32-bit instruction per cycle.
module rv32_instr_realigner #(
    parameter int          BUF_HALFWORDS = 4,
    parameter bit          ENABLE_C      = 1'b1,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_compressed,
    output logic        out_illegal,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int PW = $clog2(BUF_HALFWORDS);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(BUF_HALFWORDS);

    logic [15:0]   mem_q [BUF_HALFWORDS];
    logic [15:0]   mem_d [BUF_HALFWORDS];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q, pc_d;
    logic          skip_q, skip_d;

    logic [15:0]   h0_s, h1_s;
    logic          take16_s, avail_s, push_s, pop_s;
    logic [CW-1:0] free_s, push_n_s, pop_n_s;

    // Head decode, handshakes and output formatting from registered state.
    always_comb begin
        h0_s        = mem_q[head_q];
        h1_s        = mem_q[head_q + PW'(1)];
        take16_s    = ENABLE_C && (h0_s[1:0] != 2'b11);
        free_s      = DEPTH - count_q;
        fetch_ready = (free_s >= CW'(2));
        if (take16_s) begin
            avail_s = (count_q >= CW'(1));
            pop_n_s = CW'(1);
        end else begin
            avail_s = (count_q >= CW'(2));
            pop_n_s = CW'(2);
        end
        push_n_s  = skip_q ? CW'(1) : CW'(2);
        out_valid = avail_s && !flush;
        push_s    = fetch_valid && fetch_ready && !flush;
        pop_s     = out_valid && out_ready;
        out_pc    = pc_q;
        if (out_valid) begin
            out_instr      = take16_s ? {16'h0000, h0_s} : {h1_s, h0_s};
            out_compressed = take16_s;
            out_illegal    = !ENABLE_C && (h0_s[1:0] != 2'b11);
        end else begin
            out_instr      = 32'h0000_0000;
            out_compressed = 1'b0;
            out_illegal    = 1'b0;
        end
    end

    // Next-state: flush redirect has priority over push and pop.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;
        skip_d  = skip_q;
        if (flush) begin
            head_d  = PW'(0);
            tail_d  = PW'(0);
            count_d = CW'(0);
            if (ENABLE_C) begin
                pc_d   = {flush_pc[31:1], 1'b0};
                skip_d = flush_pc[1];
            end else begin
                pc_d   = {flush_pc[31:2], 2'b00};
                skip_d = 1'b0;
            end
        end else begin
            if (push_s) begin
                if (skip_q) begin
                    // Redirect landed on the upper parcel: drop the lower half once.
                    mem_d[tail_q] = fetch_data[31:16];
                    tail_d        = tail_q + PW'(1);
                    skip_d        = 1'b0;
                end else begin
                    mem_d[tail_q]          = fetch_data[15:0];
                    mem_d[tail_q + PW'(1)] = fetch_data[31:16];
                    tail_d                 = tail_q + PW'(2);
                end
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + pop_n_s[PW-1:0];
                pc_d   = pc_q + (take16_s ? 32'd2 : 32'd4);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + (push_s ? push_n_s : CW'(0)) - (pop_s ? pop_n_s : CW'(0));
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < BUF_HALFWORDS; i++) begin
                mem_q[i] <= 16'h0000;
            end
            head_q  <= PW'(0);
            tail_q  <= PW'(0);
            count_q <= CW'(0);
            pc_q    <= RESET_PC;
            skip_q  <= ENABLE_C ? RESET_PC[1] : 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            skip_q  <= skip_d;
        end
    end

endmodule
